// File: rtl/sr_cmd_conditioner_if.sv
// Request/pulse bundle between a command source and the SR command conditioner.
// The master drives the raw request lines; the slave returns the conditioned pulses and status flags.
`timescale 1ns/1ps
interface sr_cmd_conditioner_if;
  logic set_req_raw;
  logic clr_req_raw;
  logic s;
  logic r;
  logic busy;
  logic conflict;
  logic overrun;

  modport master (
    output set_req_raw,
    output clr_req_raw,
    input  s,
    input  r,
    input  busy,
    input  conflict,
    input  overrun
  );

  modport slave (
    input  set_req_raw,
    input  clr_req_raw,
    output s,
    output r,
    output busy,
    output conflict,
    output overrun
  );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Converts two raw, bouncing request lines into clean, mutually exclusive one-cycle s/r pulses.
// Each line is synchronized, debounced and edge-detected; an arbiter FSM then serves them.
`timescale 1ns/1ps
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int PRIO_SET        = 0
) (
  input  logic                clk,
  input  logic                reset,
  sr_cmd_conditioner_if.slave bus
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam int         SET_CH   = 0;
  localparam int         CLR_CH   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [1:0]      level_d;
  logic [1:0]      rise;
  logic [1:0]      pending;
  logic [1:0]      serve;
  logic [1:0][3:0] deb_cnt;
  logic [3:0]      gap_cnt;
  logic            gap_done;

  logic            s_q;
  logic            r_q;
  logic            conflict_q;
  logic            overrun_q;
  logic            s_next;
  logic            r_next;
  logic            conflict_next;

  assign raw = {bus.clr_req_raw, bus.set_req_raw};

  // Level only follows sync2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      deb_cnt <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2[ch] == level[ch]) begin
          deb_cnt[ch] <= 4'd0;
        end else if (deb_cnt[ch] == DEB_LAST) begin
          level[ch]   <= sync2[ch];
          deb_cnt[ch] <= 4'd0;
        end else begin
          deb_cnt[ch] <= deb_cnt[ch] + 4'd1;
        end
      end
    end
  end

  assign rise = level & ~level_d;

  // A new edge wins over service, so an edge landing on the serve cycle re-arms the channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rise[ch]) begin
          pending[ch] <= 1'b1;
        end else if (serve[ch]) begin
          pending[ch] <= 1'b0;
        end
      end
      overrun_q <= |(rise & pending & ~serve);
    end
  end

  assign gap_done = (gap_cnt == GAP_LAST);

  always_comb begin
    state_next    = state;
    s_next        = 1'b0;
    r_next        = 1'b0;
    conflict_next = 1'b0;
    serve         = '0;
    unique case (state)
      IDLE: begin
        if (pending[SET_CH] && pending[CLR_CH]) begin
          conflict_next = 1'b1;
          state_next    = PULSE;
          if (PRIO_SET != 0) begin
            s_next        = 1'b1;
            serve[SET_CH] = 1'b1;
          end else begin
            r_next        = 1'b1;
            serve[CLR_CH] = 1'b1;
          end
        end else if (pending[SET_CH]) begin
          state_next    = PULSE;
          s_next        = 1'b1;
          serve[SET_CH] = 1'b1;
        end else if (pending[CLR_CH]) begin
          state_next    = PULSE;
          r_next        = 1'b1;
          serve[CLR_CH] = 1'b1;
        end
      end
      PULSE: begin
        state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pulses are registered so s and r are glitch-free and can never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gap_cnt    <= 4'd0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_next;
      s_q        <= s_next;
      r_q        <= r_next;
      conflict_q <= conflict_next;
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= 4'd0;
      end
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.conflict = conflict_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner: per-cycle vector table on default and set-priority
// instances, plus hand-written sequences for bounce, overrun, mid-pulse reset and fast timing.
`timescale 1ns/1ps
module tb_sr_cmd_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  sr_cmd_conditioner_if if_def ();
  sr_cmd_conditioner_if if_ps ();
  sr_cmd_conditioner_if if_g15 ();
  sr_cmd_conditioner_if if_fast ();

  sr_cmd_conditioner u_def (
    .clk   (clk),
    .reset (reset),
    .bus   (if_def)
  );

  sr_cmd_conditioner #(.PRIO_SET(1)) u_ps (
    .clk   (clk),
    .reset (reset),
    .bus   (if_ps)
  );

  sr_cmd_conditioner #(.GAP_CYCLES(15)) u_g15 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_g15)
  );

  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(1), .GAP_CYCLES(0)) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (if_fast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic set_raw;
    logic clr_raw;
    logic exp_s;
    logic exp_r;
    logic exp_busy;
    logic exp_conflict;
    logic exp_overrun;
    logic exp_ps_s;
    logic exp_ps_r;
  } vec_t;

  vec_t vecs[$];
  logic bounce_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic g15_clr    [24] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic set_raw, input logic clr_raw);
    if_def.set_req_raw = set_raw;
    if_def.clr_req_raw = clr_raw;
    if_ps.set_req_raw  = set_raw;
    if_ps.clr_req_raw  = clr_raw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void addRun(input int n, input logic st, input logic cl,
                                 input logic es, input logic er, input logic eb,
                                 input logic ec, input logic eo,
                                 input logic pss, input logic psr);
    vec_t v;
    v.set_raw      = st;
    v.clr_raw      = cl;
    v.exp_s        = es;
    v.exp_r        = er;
    v.exp_busy     = eb;
    v.exp_conflict = ec;
    v.exp_overrun  = eo;
    v.exp_ps_s     = pss;
    v.exp_ps_r     = psr;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // s and r must never be high together on any instance, reset included.
  always @(negedge clk) begin
    checkOutput("inv_def_s_and_r",  int'(if_def.s & if_def.r), 0);
    checkOutput("inv_ps_s_and_r",   int'(if_ps.s & if_ps.r), 0);
    checkOutput("inv_g15_s_and_r",  int'(if_g15.s & if_g15.r), 0);
    checkOutput("inv_fast_s_and_r", int'(if_fast.s & if_fast.r), 0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s_count;
    int s_at;
    int r_count;
    int r_first;
    int r_second;
    int ovr_count;
    int ovr_at;
    int n;
    int p;
    logic is_set;
    logic val;

    // Clean set: pending after k+6, s after k+7, GAP through k+9.
    addRun(6,  1, 0,  0, 0, 0, 0, 0,  0, 0);
    addRun(1,  1, 0,  0, 0, 1, 0, 0,  0, 0);
    addRun(1,  1, 0,  1, 0, 1, 0, 0,  1, 0);
    addRun(2,  1, 0,  0, 0, 1, 0, 0,  0, 0);
    addRun(10, 1, 0,  0, 0, 0, 0, 0,  0, 0);
    addRun(12, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    // Simultaneous: winner at k+7 with conflict, loser 4 cycles later.
    addRun(6,  1, 1,  0, 0, 0, 0, 0,  0, 0);
    addRun(1,  1, 1,  0, 0, 1, 0, 0,  0, 0);
    addRun(1,  1, 1,  0, 1, 1, 1, 0,  1, 0);
    addRun(3,  1, 1,  0, 0, 1, 0, 0,  0, 0);
    addRun(1,  1, 1,  1, 0, 1, 0, 0,  0, 1);
    addRun(2,  1, 1,  0, 0, 1, 0, 0,  0, 0);
    addRun(4,  1, 1,  0, 0, 0, 0, 0,  0, 0);
    addRun(10, 0, 0,  0, 0, 0, 0, 0,  0, 0);

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    if_g15.set_req_raw  = 1'b0;
    if_g15.clr_req_raw  = 1'b0;
    if_fast.set_req_raw = 1'b0;
    if_fast.clr_req_raw = 1'b0;
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_def_s",        if_def.s, 0);
    checkOutput("rst_def_r",        if_def.r, 0);
    checkOutput("rst_def_busy",     if_def.busy, 0);
    checkOutput("rst_def_conflict", if_def.conflict, 0);
    checkOutput("rst_def_overrun",  if_def.overrun, 0);
    checkOutput("rst_ps_busy",      if_ps.busy, 0);
    checkOutput("rst_g15_busy",     if_g15.busy, 0);
    checkOutput("rst_fast_busy",    if_fast.busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].set_raw, vecs[i].clr_raw);
      tick();
      checkOutput($sformatf("v%0d_def_s", i),        if_def.s,        vecs[i].exp_s);
      checkOutput($sformatf("v%0d_def_r", i),        if_def.r,        vecs[i].exp_r);
      checkOutput($sformatf("v%0d_def_busy", i),     if_def.busy,     vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_def_conflict", i), if_def.conflict, vecs[i].exp_conflict);
      checkOutput($sformatf("v%0d_def_overrun", i),  if_def.overrun,  vecs[i].exp_overrun);
      checkOutput($sformatf("v%0d_ps_s", i),         if_ps.s,         vecs[i].exp_ps_s);
      checkOutput($sformatf("v%0d_ps_r", i),         if_ps.r,         vecs[i].exp_ps_r);
      checkOutput($sformatf("v%0d_ps_busy", i),      if_ps.busy,      vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_ps_conflict", i),  if_ps.conflict,  vecs[i].exp_conflict);
      checkOutput($sformatf("v%0d_ps_overrun", i),   if_ps.overrun,   vecs[i].exp_overrun);
    end

    // Bounce: 2-cycle glitches are rejected; one pulse 7 edges into the final hold.
    s_count = 0;
    s_at    = -1;
    r_count = 0;
    for (int i = 0; i < 8; i++) begin
      if_def.set_req_raw = bounce_pat[i];
      tick();
      if (if_def.s) s_count++;
      if (if_def.r) r_count++;
    end
    if_def.set_req_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (if_def.s) begin
        s_count++;
        s_at = i;
      end
      if (if_def.r) r_count++;
    end
    checkOutput("bounce_s_count", s_count, 1);
    checkOutput("bounce_s_time",  s_at, 7);
    checkOutput("bounce_r_count", r_count, 0);
    if_def.set_req_raw = 1'b0;
    repeat (12) tick();

    // Overrun: third clr edge lands while the second is still pending in a 15-cycle gap.
    r_count   = 0;
    r_first   = -1;
    r_second  = -1;
    ovr_count = 0;
    ovr_at    = -1;
    s_count   = 0;
    for (int i = 0; i < 45; i++) begin
      if_g15.clr_req_raw = (i < 24) ? g15_clr[i] : 1'b0;
      tick();
      if (if_g15.r) begin
        r_count++;
        if (r_first < 0) r_first = i;
        else r_second = i;
      end
      if (if_g15.overrun) begin
        ovr_count++;
        ovr_at = i;
      end
      if (if_g15.s) s_count++;
    end
    checkOutput("ovr_r_count",  r_count, 2);
    checkOutput("ovr_r_first",  r_first, 7);
    checkOutput("ovr_r_second", r_second, 24);
    checkOutput("ovr_count",    ovr_count, 1);
    checkOutput("ovr_time",     ovr_at, 22);
    checkOutput("ovr_s_count",  s_count, 0);
    checkOutput("ovr_end_busy", if_g15.busy, 0);

    // Reset mid-pulse drops s without a clock; held request yields one fresh pulse.
    if_def.set_req_raw = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("mid_pre_s", if_def.s, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_s",    if_def.s, 0);
    checkOutput("mid_rst_busy", if_def.busy, 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    s_count = 0;
    s_at    = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (if_def.s) begin
        s_count++;
        s_at = i;
      end
    end
    checkOutput("mid_post_s_count", s_count, 1);
    checkOutput("mid_post_s_time",  s_at, 7);
    if_def.set_req_raw = 1'b0;
    repeat (12) tick();

    // Fast instance: alternating set/clr edges every 6 cycles, pulse 4 edges after each.
    for (int i = 0; i < 36; i++) begin
      n      = i / 6;
      p      = i % 6;
      is_set = ((n % 2) == 0);
      val    = (p < 3);
      if_fast.set_req_raw = is_set & val;
      if_fast.clr_req_raw = ~is_set & val;
      tick();
      checkOutput($sformatf("fast%0d_s", i), if_fast.s, int'((p == 4) && is_set));
      checkOutput($sformatf("fast%0d_r", i), if_fast.r, int'((p == 4) && !is_set));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
